sleep_wake_ctrl: RTL
====================

Name: sleep_wake_ctrl

Overview:
- Responder side of the CPU sleep request; runs in the clk_1mhz domain next to the power-up LED counter.
- Synchronises the CPU's level sleep request and acknowledges it with a 4-phase handshake.
- While asleep, gates the CPU clock enable and runs a wake-up timer; wakes on timer expiry or on a synchronised external wake event (e.g. USB out_valid).
- Reports the wake cause and drives the status LED pattern.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (sleep_req_i, wake_i); legal range 2..3.
- GUARD_CYCLES, 16, clk_1mhz cycles sleep_req must stay high before sleep is entered; legal range 1..255.
- WAKE_TICKS, 1000000, timer load value in clk_1mhz cycles (1 s); 0 disables the timer.
- TMR_W, 20, timer width; WAKE_TICKS must fit in TMR_W bits.
- BLINK_LOG2, 17, LED toggles at bit BLINK_LOG2 of a free-running counter while asleep.

Ports:
- clk_1mhz  in  1  1 MHz clock.
- rstn  in  1  reset, asynchronous, active-low.
- sleep_req_i  in  1  CPU sleep request, level, from the clk_2mhz domain (asynchronous here).
- wake_i  in  1  external wake source, level, asynchronous.
- sleep_ack_o  out  1  4-phase acknowledge to the CPU, registered.
- cpu_clk_en_o  out  1  CPU clock enable; 0 while asleep, registered.
- wake_cause_o  out  2  00 none, 01 timer, 10 external, 11 both in same cycle; registered.
- led_o  out  1  status LED, 1 = on.

Behaviour:
- Reset values: sleep_ack_o=0, cpu_clk_en_o=1, wake_cause_o=00, led_o=1, state=RUN, timer=0, guard count=0, synchroniser flops=0.
- Deassertion of rstn takes effect on the next clk_1mhz edge.
- Synchronisers: req_s and wake_s are the last synchroniser stage (latency SYNC_STAGES cycles).
- wake_rise = wake_s & ~wake_s_d (one extra flop, wake_s_d); detection is on the rising edge only.
- RUN:
  - ack=0, clk_en=1, led=1.
  - req_s=1 -> GUARD and load guard count with GUARD_CYCLES-1.
- GUARD:
  - req_s=0 -> RUN (abort; ack never asserted).
  - Otherwise decrement; at count 0 -> SLEEP, load timer with WAKE_TICKS, clear wake_cause.
- SLEEP:
  - ack=1 and clk_en=0, both registered on entry cycle +1.
  - led follows blink bit.
  - Timer decrements each cycle if WAKE_TICKS!=0.
  - Timer reaching 0 (tmr_exp) or wake_rise -> WAKE; cause={wake_rise, tmr_exp}.
  - Both in the same cycle -> cause 11.
  - A wake_i already high on entry does not wake (edge only).
  - req_s dropping in SLEEP -> WAKE with cause 00 (CPU-initiated wake).
- WAKE:
  - clk_en=1 on the next cycle; ack stays 1; led=1.
  - Wait for req_s=0, then ack=0 -> RUN.
  - wake_cause_o holds until the next GUARD->SLEEP transition.
- Handshake rule: ack rises only after req high for GUARD_CYCLES synced cycles; ack falls only after req low. No ack pulse without req.
- Arithmetic:
  - Timer is unsigned TMR_W bits, no wrap; it stops at 0.
  - Blink counter is free-running BLINK_LOG2+1 bits and wraps.
- Reset mid-SLEEP: immediate asynchronous return to reset values (clk_en=1, ack=0).
- wake_i toggling during GUARD is ignored; no cause is latched.

Test Plan:
1. Reset: hold rstn=0 with sleep_req_i=1 -> ack=0, clk_en=1, cause=00, led=1. Release, keep req=1 -> ack rises exactly SYNC_STAGES+GUARD_CYCLES+1 (=19) cycles later; clk_en=0 the same cycle.
2. Abort: req=1 for 10 cycles then 0 -> ack never asserts, clk_en stays 1, state returns to RUN.
3. Timer wake: WAKE_TICKS=50, req held -> clk_en returns to 1 exactly 50 cycles after SLEEP entry, cause=01. Drop req -> ack=0 after SYNC_STAGES+1 cycles.
4. External wake: wake_i rises 20 cycles into SLEEP -> clk_en=1 after SYNC_STAGES+2 cycles, cause=10. wake_i held high before entry -> no wake.
5. Simultaneous: wake_rise aligned with timer expiry -> cause=11. Req drop in SLEEP -> WAKE with cause=00.
6. Reset mid-SLEEP: rstn pulse low -> clk_en=1, ack=0, led=1 asynchronously. Relaunched handshake then completes normally.

Source files
------------

// File: rtl/sleep_wake_ctrl.sv
// -----------------------------------------------------------------------------
// sleep_wake_ctrl
//
// Responder side of the CPU sleep request, in the clk_1mhz domain.
// The CPU raises a level sleep request. After it has stayed high for a guard
// period, this block acknowledges it, gates the CPU clock and starts a wake-up
// timer. It wakes on timer expiry, on a rising edge of the external wake
// source, or when the CPU withdraws its request. The acknowledge follows a
// 4-phase handshake, and the wake cause is reported until the next sleep.
//
// Ports:
//   clk_1mhz      in   1  1 MHz clock
//   rstn          in   1  asynchronous active-low reset
//   sleep_req_i   in   1  CPU sleep request, level, asynchronous to clk_1mhz
//   wake_i        in   1  external wake source, level, asynchronous
//   sleep_ack_o   out  1  4-phase acknowledge to the CPU (registered)
//   cpu_clk_en_o  out  1  CPU clock enable, 0 while asleep (registered)
//   wake_cause_o  out  2  00 none/CPU, 01 timer, 10 external, 11 both (registered)
//   led_o         out  1  status LED, 1 = on (registered)
//
// Output timing: acknowledge, clock enable, LED and cause are registered from
// the current state, so they follow a state change by one clock. The one
// exception is the acknowledge release. It is taken from the next state, so
// it drops on the same edge that returns the FSM to RUN.
// -----------------------------------------------------------------------------
module sleep_wake_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 16,
    parameter int WAKE_TICKS   = 1000000,
    parameter int TMR_W        = 20,
    parameter int BLINK_LOG2   = 17
) (
    input  logic       clk_1mhz,
    input  logic       rstn,
    input  logic       sleep_req_i,
    input  logic       wake_i,
    output logic       sleep_ack_o,
    output logic       cpu_clk_en_o,
    output logic [1:0] wake_cause_o,
    output logic       led_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [7:0]       GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(WAKE_TICKS);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
    localparam logic             TMR_ON     = (WAKE_TICKS != 0);

    // Synchroniser chains and the wake edge detector.
    logic [SYNC_STAGES-1:0] req_sync_r;
    logic [SYNC_STAGES-1:0] wake_sync_r;
    logic                   wake_s_d_r;
    logic                   req_s;
    logic                   wake_s;
    logic                   wake_rise_s;

    // FSM state and datapath registers.
    state_t                 state_r;
    state_t                 next_state_s;
    logic [7:0]             guard_r;
    logic [7:0]             guard_nxt_s;
    logic [TMR_W-1:0]       tmr_r;
    logic [TMR_W-1:0]       tmr_nxt_s;
    logic [1:0]             cause_r;
    logic [1:0]             cause_nxt_s;
    logic                   tmr_exp_s;
    logic [BLINK_LOG2:0]    blink_r;

    // Values for the registered outputs.
    logic                   ack_nxt_s;
    logic                   clk_en_nxt_s;
    logic                   led_nxt_s;

    assign req_s       = req_sync_r[SYNC_STAGES-1];
    assign wake_s      = wake_sync_r[SYNC_STAGES-1];
    assign wake_rise_s = wake_s & ~wake_s_d_r;

    // The timer expires on the cycle whose decrement brings it to zero.
    assign tmr_exp_s   = (state_r == ST_SLEEP) && TMR_ON && (tmr_r == TMR_ONE);

    // Bring the asynchronous request and wake inputs into clk_1mhz, and keep
    // one delayed copy of the wake input for rising-edge detection.
    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            req_sync_r  <= '0;
            wake_sync_r <= '0;
            wake_s_d_r  <= 1'b0;
        end else begin
            req_sync_r  <= {req_sync_r[SYNC_STAGES-2:0], sleep_req_i};
            wake_sync_r <= {wake_sync_r[SYNC_STAGES-2:0], wake_i};
            wake_s_d_r  <= wake_s;
        end
    end

    // State register, guard counter, wake timer, latched cause and blink counter.
    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RUN;
            guard_r <= 8'd0;
            tmr_r   <= TMR_ZERO;
            cause_r <= 2'b00;
            blink_r <= '0;
        end else begin
            state_r <= next_state_s;
            guard_r <= guard_nxt_s;
            tmr_r   <= tmr_nxt_s;
            cause_r <= cause_nxt_s;
            blink_r <= blink_r + 1'b1;
        end
    end

    // Next-state logic with guard countdown, timer countdown and wake-cause capture.
    always_comb begin
        next_state_s = state_r;
        guard_nxt_s  = guard_r;
        tmr_nxt_s    = tmr_r;
        cause_nxt_s  = cause_r;
        case (state_r)
            ST_RUN: begin
                if (req_s) begin
                    next_state_s = ST_GUARD;
                    guard_nxt_s  = GUARD_LOAD;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_GUARD: begin
                if (!req_s) begin
                    next_state_s = ST_RUN;
                end else if (guard_r <= 8'd1) begin
                    // The last decrement lands on zero: commit to sleep.
                    next_state_s = ST_SLEEP;
                    guard_nxt_s  = 8'd0;
                    tmr_nxt_s    = TMR_LOAD;
                    cause_nxt_s  = 2'b00;
                end else begin
                    guard_nxt_s  = guard_r - 8'd1;
                end
            end
            ST_SLEEP: begin
                if (TMR_ON && (tmr_r != TMR_ZERO)) begin
                    tmr_nxt_s = tmr_r - TMR_ONE;
                end else begin
                    tmr_nxt_s = tmr_r;
                end
                // A request withdrawn by the CPU wakes with cause 00.
                if (tmr_exp_s || wake_rise_s || !req_s) begin
                    next_state_s = ST_WAKE;
                    cause_nxt_s  = {wake_rise_s, tmr_exp_s};
                end else begin
                    next_state_s = ST_SLEEP;
                end
            end
            ST_WAKE: begin
                if (!req_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_WAKE;
                end
            end
            default: begin
                next_state_s = ST_RUN;
            end
        endcase
    end

    // Output decode. Ack is held through SLEEP/WAKE and released with the return to RUN.
    always_comb begin
        ack_nxt_s    = 1'b0;
        clk_en_nxt_s = 1'b1;
        led_nxt_s    = 1'b1;
        if (((state_r == ST_SLEEP) || (state_r == ST_WAKE)) && (next_state_s != ST_RUN)) begin
            ack_nxt_s = 1'b1;
        end else begin
            ack_nxt_s = 1'b0;
        end
        if (state_r == ST_SLEEP) begin
            clk_en_nxt_s = 1'b0;
            led_nxt_s    = blink_r[BLINK_LOG2];
        end else begin
            clk_en_nxt_s = 1'b1;
            led_nxt_s    = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            sleep_ack_o  <= 1'b0;
            cpu_clk_en_o <= 1'b1;
            wake_cause_o <= 2'b00;
            led_o        <= 1'b1;
        end else begin
            sleep_ack_o  <= ack_nxt_s;
            cpu_clk_en_o <= clk_en_nxt_s;
            wake_cause_o <= cause_r;
            led_o        <= led_nxt_s;
        end
    end

endmodule
